// File: rtl/butterfly_pipe.sv
// butterfly_pipe
//   Pipelined radix-2 DIT butterfly with twiddle multiply:
//     x1 = a + b*W,  x2 = a - b*W
//   Three register stages (products / rounded product / sum+reduce) behind a
//   single pipeline enable, so one butterfly per clock when not back-pressured.
//
// Ports
//   clock, reset_n        : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   : input handshake
//   ar, ai, br, bi        : operands a and b, signed DW bits per component
//   wr, wi                : twiddle, signed Q1.(TW-1); -2^(TW-1) is exactly -1.0
//   tw_bypass             : 1 -> W taken as exactly 1.0
//   scale                 : 1 -> results arithmetic-shifted right by one
//   out_valid / out_ready : output handshake
//   x1r, x1i, x2r, x2i    : results, signed DW bits
//   ovf                   : sticky overflow flag
//
// Configuration
//   BUTTERFLY_SAT_EN defined   : final reduction saturates, clipping sets ovf.
//   BUTTERFLY_SAT_EN undefined : final reduction wraps, ovf is constant 0.

module butterfly_pipe #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] ar,
    input  logic signed [DW-1:0] ai,
    input  logic signed [DW-1:0] br,
    input  logic signed [DW-1:0] bi,
    input  logic signed [TW-1:0] wr,
    input  logic signed [TW-1:0] wi,
    input  logic                 tw_bypass,
    input  logic                 scale,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] x1r,
    output logic signed [DW-1:0] x1i,
    output logic signed [DW-1:0] x2r,
    output logic signed [DW-1:0] x2i,
    output logic                 ovf
);

    localparam int PW  = DW + TW;      // single product
    localparam int SW  = DW + TW + 1;  // sum/difference of two products
    localparam int P3W = DW + 1;       // rounded product b*W
    localparam int AW  = DW + 2;       // a +/- p before reduction

    // Half an LSB of the Q1.(TW-1) result, for round-half-up
    localparam logic signed [SW-1:0] RND = SW'(1) <<< (TW - 2);

    function automatic logic signed [P3W-1:0] round_shift(input logic signed [SW-1:0] v);
        return P3W'((v + RND) >>> (TW - 1));
    endfunction

`ifdef BUTTERFLY_SAT_EN
    localparam logic signed [AW-1:0] HI = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] LO = {3'b111, {(DW-1){1'b0}}};

    function automatic logic signed [DW-1:0] reduce(input logic signed [AW-1:0] v);
        if (v > HI)      return DW'(HI);
        else if (v < LO) return DW'(LO);
        else             return DW'(v);
    endfunction

    function automatic logic clipped(input logic signed [AW-1:0] v);
        return (v > HI) || (v < LO);
    endfunction
`else
    function automatic logic signed [DW-1:0] reduce(input logic signed [AW-1:0] v);
        return DW'(v);
    endfunction
`endif

    // Whole pipeline moves together; a full output register blocks everything
    logic en;
    logic out_valid_q;
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // ---------------- Stage 1: four partial products ----------------
    logic signed [PW-1:0] prr_p1_d, pii_p1_d, pri_p1_d, pir_p1_d;
    logic signed [PW-1:0] prr_p1_q, pii_p1_q, pri_p1_q, pir_p1_q;
    logic signed [DW-1:0] ar_p1_q, ai_p1_q, br_p1_q, bi_p1_q;
    logic                 byp_p1_q, scl_p1_q, vld_p1_q;

    always_comb begin
        prr_p1_d = PW'(br) * PW'(wr);
        pii_p1_d = PW'(bi) * PW'(wi);
        pri_p1_d = PW'(br) * PW'(wi);
        pir_p1_d = PW'(bi) * PW'(wr);
    end

    always_ff @(posedge clock) begin
        if (en) begin
            prr_p1_q <= prr_p1_d;
            pii_p1_q <= pii_p1_d;
            pri_p1_q <= pri_p1_d;
            pir_p1_q <= pir_p1_d;
            ar_p1_q  <= ar;
            ai_p1_q  <= ai;
            br_p1_q  <= br;
            bi_p1_q  <= bi;
            byp_p1_q <= tw_bypass;
            scl_p1_q <= scale;
        end
    end

    // ---------------- Stage 2: complex product, rounded to DW+1 bits ----------------
    logic signed [P3W-1:0] pr_p2_d, pi_p2_d;
    logic signed [P3W-1:0] pr_p2_q, pi_p2_q;
    logic signed [DW-1:0]  ar_p2_q, ai_p2_q;
    logic                  scl_p2_q, vld_p2_q;

    always_comb begin
        if (byp_p1_q) begin
            // W = 1.0 exactly: pass b through, no rounding error
            pr_p2_d = P3W'(br_p1_q);
            pi_p2_d = P3W'(bi_p1_q);
        end else begin
            pr_p2_d = round_shift(SW'(prr_p1_q) - SW'(pii_p1_q));
            pi_p2_d = round_shift(SW'(pri_p1_q) + SW'(pir_p1_q));
        end
    end

    always_ff @(posedge clock) begin
        if (en) begin
            pr_p2_q  <= pr_p2_d;
            pi_p2_q  <= pi_p2_d;
            ar_p2_q  <= ar_p1_q;
            ai_p2_q  <= ai_p1_q;
            scl_p2_q <= scl_p1_q;
        end
    end

    // ---------------- Stage 3: add/subtract, scale, reduce to DW bits ----------------
    logic signed [AW-1:0] s1r, s1i, s2r, s2i;
    logic signed [DW-1:0] x1r_d, x1i_d, x2r_d, x2i_d;
    logic signed [DW-1:0] x1r_q, x1i_q, x2r_q, x2i_q;

    always_comb begin
        s1r = AW'(ar_p2_q) + AW'(pr_p2_q);
        s1i = AW'(ai_p2_q) + AW'(pi_p2_q);
        s2r = AW'(ar_p2_q) - AW'(pr_p2_q);
        s2i = AW'(ai_p2_q) - AW'(pi_p2_q);
        if (scl_p2_q) begin
            s1r = s1r >>> 1;
            s1i = s1i >>> 1;
            s2r = s2r >>> 1;
            s2i = s2i >>> 1;
        end
        x1r_d = reduce(s1r);
        x1i_d = reduce(s1i);
        x2r_d = reduce(s2r);
        x2i_d = reduce(s2i);
    end

    // Stage valids and the visible outputs are cleared by reset; in-flight
    // data registers need no reset because the valids qualify them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            x1r_q       <= '0;
            x1i_q       <= '0;
            x2r_q       <= '0;
            x2i_q       <= '0;
        end else if (en) begin
            vld_p1_q    <= in_valid;
            vld_p2_q    <= vld_p1_q;
            out_valid_q <= vld_p2_q;
            x1r_q       <= x1r_d;
            x1i_q       <= x1i_d;
            x2r_q       <= x2r_d;
            x2i_q       <= x2i_d;
        end
    end

`ifdef BUTTERFLY_SAT_EN
    logic clip_d;
    logic ovf_q;

    assign clip_d = clipped(s1r) || clipped(s1i) || clipped(s2r) || clipped(s2i);

    // Only a real sample entering the output register may raise the flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (en && vld_p2_q && clip_d) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign x1r       = x1r_q;
    assign x1i       = x1i_q;
    assign x2r       = x2r_q;
    assign x2i       = x2i_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe
//   Self-checking bench for butterfly_pipe (DW=16, TW=16). Accepted inputs are
//   turned into expected results by an arithmetic model and queued; every
//   output transfer pops and compares. Directed cases, a stalled stream,
//   reset in flight and a randomized handshake run follow.
//   Honours BUTTERFLY_SAT_EN the same way as the design.

module tb_butterfly_pipe;

    localparam int DW = 16;
    localparam int TW = 16;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] ar, ai, br, bi;
    logic signed [TW-1:0] wr, wi;
    logic                 tw_bypass;
    logic                 scale;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] x1r, x1i, x2r, x2i;
    logic                 ovf;

    always #5 clock = ~clock;

    butterfly_pipe #(.DW(DW), .TW(TW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ar        (ar),
        .ai        (ai),
        .br        (br),
        .bi        (bi),
        .wr        (wr),
        .wi        (wi),
        .tw_bypass (tw_bypass),
        .scale     (scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x1r       (x1r),
        .x1i       (x1i),
        .x2r       (x2r),
        .x2i       (x2i),
        .ovf       (ovf)
    );

    typedef struct {
        longint x1r;
        longint x1i;
        longint x2r;
        longint x2i;
        bit     clip;
    } exp_t;

    exp_t    exp_q[$];
    int      total = 0;
    int      bad   = 0;
    bit      exp_ovf;
    bit      accepted;
    bit      was_stalled;
    longint  prev_x1r, prev_x2i;

    task automatic chk(input string tag, input longint obs, input longint expv);
        total++;
        if (obs != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint wrapb(input longint v, input int bits);
        longint m = 64'sd1 <<< bits;
        longint r = v & (m - 1);
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    function automatic longint fdiv(input longint n, input longint d);
        longint qv = n / d;
        if ((n % d != 0) && (n < 0)) qv = qv - 1;
        return qv;
    endfunction

    function automatic longint reduce_m(input longint v, output bit clip);
        longint hi = (64'sd1 <<< (DW - 1)) - 1;
        longint lo = -(64'sd1 <<< (DW - 1));
        clip = 1'b0;
`ifdef BUTTERFLY_SAT_EN
        if (v > hi) begin clip = 1'b1; return hi; end
        if (v < lo) begin clip = 1'b1; return lo; end
        return v;
`else
        if (v > hi || v < lo) return wrapb(v, DW);
        return v;
`endif
    endfunction

    function automatic exp_t model(input longint a_r, input longint a_i,
                                   input longint b_r, input longint b_i,
                                   input longint w_r, input longint w_i,
                                   input bit byp, input bit sc);
        exp_t   e;
        longint p_r, p_i;
        longint s[4];
        bit     c[4];
        if (byp) begin
            p_r = b_r;
            p_i = b_i;
        end else begin
            // Q1.15 product, round half up, kept in DW+1 bits
            p_r = wrapb(fdiv(b_r * w_r - b_i * w_i + 16384, 32768), DW + 1);
            p_i = wrapb(fdiv(b_r * w_i + b_i * w_r + 16384, 32768), DW + 1);
        end
        s[0] = a_r + p_r;
        s[1] = a_i + p_i;
        s[2] = a_r - p_r;
        s[3] = a_i - p_i;
        for (int k = 0; k < 4; k++) begin
            if (sc) s[k] = fdiv(s[k], 2);
            s[k] = reduce_m(s[k], c[k]);
        end
        e.x1r  = s[0];
        e.x1i  = s[1];
        e.x2r  = s[2];
        e.x2i  = s[3];
        e.clip = c[0] | c[1] | c[2] | c[3];
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input int a_r, input int a_i, input int b_r, input int b_i,
                          input int w_r, input int w_i, input bit byp, input bit sc);
        ar = 16'(a_r); ai = 16'(a_i); br = 16'(b_r); bi = 16'(b_i);
        wr = 16'(w_r); wi = 16'(w_i); tw_bypass = byp; scale = sc;
    endtask

    task automatic rand_in();
        ar = 16'($urandom); ai = 16'($urandom);
        br = 16'($urandom); bi = 16'($urandom);
        wr = 16'($urandom); wi = 16'($urandom);
        if ($urandom_range(0, 7) == 0) br = 16'h8000;
        if ($urandom_range(0, 7) == 0) wr = 16'h8000;
        if ($urandom_range(0, 7) == 0) wi = 16'h8000;
        if ($urandom_range(0, 7) == 0) ar = 16'h7fff;
        tw_bypass = ($urandom_range(0, 3) == 0);
        scale     = $urandom_range(0, 1) == 1;
    endtask

    // One clock: inputs already driven at posedge+1; handshakes evaluated at
    // the negedge before the edge where they take effect.
    task automatic cycle();
        exp_t e;
        @(negedge clock);
        if (was_stalled) begin
            chk("hold_x1r", x1r, prev_x1r);
            chk("hold_x2i", x2i, prev_x2i);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                exp_ovf = exp_ovf | e.clip;
                chk("x1r", x1r, e.x1r);
                chk("x1i", x1i, e.x1i);
                chk("x2r", x2r, e.x2r);
                chk("x2i", x2i, e.x2i);
                chk("ovf", ovf, exp_ovf);
            end
        end
        accepted = in_valid && in_ready;
        if (accepted)
            exp_q.push_back(model(longint'(ar), longint'(ai), longint'(br), longint'(bi),
                                  longint'(wr), longint'(wi), tw_bypass, scale));
        was_stalled = out_valid && !out_ready;
        prev_x1r    = x1r;
        prev_x2i    = x2i;
        @(posedge clock);
        #1;
    endtask

    // Single butterfly into an empty pipe: latency and constant results
    task automatic run_one(input string tag,
                           input int a_r, input int a_i, input int b_r, input int b_i,
                           input int w_r, input int w_i, input bit byp, input bit sc,
                           input int e1r, input int e1i, input int e2r, input int e2i);
        set_in(a_r, a_i, b_r, b_i, w_r, w_i, byp, sc);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        cycle();
        chk({tag, "_lat2"}, out_valid, 0);
        cycle();
        chk({tag, "_lat3"}, out_valid, 1);
        chk({tag, "_x1r"}, x1r, e1r);
        chk({tag, "_x1i"}, x1i, e1i);
        chk({tag, "_x2r"}, x2r, e2r);
        chk({tag, "_x2i"}, x2i, e2i);
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        exp_ovf     = 1'b0;
        accepted    = 1'b0;
        was_stalled = 1'b0;
        prev_x1r    = 0;
        prev_x2i    = 0;
        set_in(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_x1r", x1r, 0);
        chk("rst_x2i", x2i, 0);
        chk("rst_ovf", ovf, 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("idle_in_ready", in_ready, 1);

        // Directed cases
        run_one("t1_bypass", 1000, 0, 500, 0, 0, 0, 1'b1, 1'b0, 1500, 0, 500, 0);
        run_one("t2_minus_j", 1000, 0, 500, 0, 0, -32768, 1'b0, 1'b0, 1000, -500, 1000, 500);
        run_one("t3_scale", 30000, 0, 30000, 0, 0, 0, 1'b1, 1'b1, 30000, 0, 0, 0);
        chk("t3_ovf", ovf, 0);
`ifdef BUTTERFLY_SAT_EN
        run_one("t4_noscale", 30000, 0, 30000, 0, 0, 0, 1'b1, 1'b0, 32767, 0, 0, 0);
        chk("t4_ovf", ovf, 1);
`else
        run_one("t4_noscale", 30000, 0, 30000, 0, 0, 0, 1'b1, 1'b0, -5536, 0, 0, 0);
        chk("t4_ovf", ovf, 0);
`endif
        run_one("t_w_half", 100, -200, 1000, -3000, 16384, -16384, 1'b0, 1'b0,
                -900, -2200, 1100, 1800);

        // Stream of 8 with out_ready low for 5 cycles mid-stream
        sent     = 0;
        accepted = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 60 && (sent < 8 || exp_q.size() > 0); k++) begin
            if (sent < 8 && (!in_valid || accepted)) begin
                rand_in();
                in_valid = 1'b1;
            end else if (sent >= 8) begin
                in_valid = 1'b0;
            end
            out_ready = !(k >= 4 && k < 9);
            if (k == 6) begin
                #1;
                chk("stall_out_valid", out_valid, 1);
                chk("stall_in_ready", in_ready, 0);
            end
            cycle();
            if (accepted) sent++;
        end
        chk("stream_sent", sent, 8);
        chk("stream_drained", exp_q.size(), 0);

        // Reset with samples in flight
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_in(1234 + k, -77, 321, 45, 20000, -5000, 1'b0, 1'b0);
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        chk("pre_rst_out_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_x1r", x1r, 0);
        chk("midrst_x1i", x1i, 0);
        chk("midrst_x2r", x2r, 0);
        chk("midrst_x2i", x2i, 0);
        chk("midrst_ovf", ovf, 0);
        exp_q.delete();
        exp_ovf     = 1'b0;
        was_stalled = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) cycle();
        chk("post_rst_quiet", out_valid, 0);

        // Randomized traffic with random back-pressure
        accepted = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!(in_valid && !accepted)) begin
                rand_in();
                in_valid = ($urandom_range(0, 4) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) cycle();
        chk("rand_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
